mcu_bus_decoder: RTL and testbench
==================================

// Module: mcu_bus_decoder
// PURPOSE
//  Upstream front end of the TFT/SDRAM controller: samples the asynchronous 8080-style MCU bus (CS/RS/WR/RD/DATA),
//  decodes command/data writes into control registers (PWM level, draw window) and, in GRAM-write mode, emits
//  a pixel stream with window-walking X/Y addresses to the SDRAM frame-buffer writer through a valid/ready FIFO.
// PARAMETERS
//  H_RES        800  panel columns; column registers clamp to H_RES-1
//  V_RES        480  panel rows; row registers clamp to V_RES-1
//  SYNC_STAGES  2    flops in each CS/RS/WR/RD/DATA synchroniser (>=2)
//  FIFO_DEPTH   2    pixel FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1   system clock
//  RST        in   1   synchronous reset, active-high
//  CS         in   1   MCU chip select, active-low, asynchronous
//  RS         in   1   0 = command index write, 1 = data write
//  WR         in   1   write strobe, active-low; write commits on rising edge
//  RD         in   1   read strobe, active-low (used only with MCU_READBACK_EN)
//  DATA       io   16  MCU data bus; input only unless MCU_READBACK_EN
//  pwm_level  out  4   backlight duty, 0..15
//  row_s/row_e out 9   window rows, start/end
//  col_s/col_e out 10  window columns, start/end
//  pix_valid  out  1   FIFO head valid
//  pix_ready  in   1   downstream accepts head when valid&ready
//  pix_data   out  16  RGB565 pixel
//  pix_x/pix_y out 10/9 pixel address
//  ovf        out  1   sticky: pixel dropped on full FIFO
// BEHAVIOUR
//  - Reset: pwm_level=0, row_s=0, col_s=0, row_e=V_RES-1, col_e=H_RES-1, pix_valid=0, ovf=0, FIFO empty, state IDLE, cmd=0.
//  - Synchronised WR rising edge while CS low = one write event; DATA taken from its synchronised copy in the same cycle.
//    Event visible on outputs 1 clk after detection (<= SYNC_STAGES+2 clk after pin edge); MCU holds DATA >= 4 clk after WR rise.
//  - RS=0 event: cmd <= DATA[7:0]. 0x0F additionally loads x=col_s, y=row_s, clears ovf, state -> GRAM; any other cmd -> CMD.
//  - RS=1 event in CMD: 0x01 pwm_level<=DATA[3:0]; 0x02 row_s; 0x03 col_s; 0x06 row_e; 0x07 col_e; others ignored.
//    Row/col values > V_RES-1/H_RES-1 clamp to the limit. Registers keep value across CS cycles.
//  - RS=1 event in GRAM: push {DATA,x,y}; then x++; x==col_e -> x=col_s, y++; also y==row_e -> y=row_s (full wrap).
//    If col_e<col_s (row_e<row_s) the end is taken equal to start (single column/row).
//  - FIFO full at push: pixel dropped, x/y still advance, ovf<=1. Push and pop in same cycle on full FIFO: accepted, no ovf.
//  - States: IDLE (CS high) -> CMD on first RS=0 event; CMD <-> GRAM via cmd writes; CS sync rising -> IDLE from any state.
//  - RS=1 event in IDLE (no cmd since CS fell) is ignored. Window writes during GRAM take effect at next 0x0F.
//  - Reset mid-burst: FIFO flushed, pix_valid=0 next cycle, all registers to reset values.
// CONFIGURATION
//  MCU_READBACK_EN defined: while CS low, RS high, RD low (synchronised), DATA driven with register selected by cmd
//   (0x01 -> {12'h0,pwm_level}, 0x02/03/06/07 -> zero-extended window value, else 16'h0000); DATA Hi-Z otherwise.
//  Not defined: DATA never driven, RD ignored.
// STRUCTURE
//  Shared package/header tft_bus_defs: command codes (CMD_PWM=0x01, CMD_ROW_S=0x02, CMD_COL_S=0x03, CMD_ROW_E=0x06,
//   CMD_COL_E=0x07, CMD_GRAM_WR=0x0F), state encoding, H_RES/V_RES defaults.
//  Sub-module pix_fifo: synchronous FIFO, width 35 ({data,x,y}), depth FIFO_DEPTH, full/empty flags, first-word-fall-through.
// TESTING
//  1 RST high 3 clk -> all outputs at reset values, pix_valid=0, DATA Hi-Z.
//  2 CS low; RS=0 write 0x0001; RS=1 write 0x0002 -> pwm_level=2 within 6 clk of WR rise.
//  3 Window rows 470..479, cols 790..799, cmd 0x0F, pixels 0x001F+i, pix_ready=1 -> pixel0 (790,470,0x001F),
//    pixel9 (799,470,0x0028), pixel10 (790,471,0x0029), pixel100 wraps to (790,470,0x0083).
//  4 pix_ready=0, GRAM mode, 3 pixel writes -> FIFO holds first 2, ovf=1; new 0x0F cmd -> ovf=0.
//  5 Write col_e=900 -> col_e=799; RST asserted after 5 GRAM pixels -> pix_valid=0 next clk, col_e=799, state IDLE.
//  6 MCU_READBACK_EN: cmd 0x07, RD low -> DATA=16'd799 after sync; RD high -> Hi-Z; without macro DATA stays Hi-Z.

Source files
------------

// File: rtl/tft_bus_defs_pkg.sv
// Shared definitions for the TFT MCU bus front end: command codes, bus state
// encoding, panel defaults and a clamping helper.
package tft_bus_defs_pkg;

  localparam int unsigned HResDefault = 800;
  localparam int unsigned VResDefault = 480;

  localparam logic [7:0] CMD_PWM     = 8'h01;
  localparam logic [7:0] CMD_ROW_S   = 8'h02;
  localparam logic [7:0] CMD_COL_S   = 8'h03;
  localparam logic [7:0] CMD_ROW_E   = 8'h06;
  localparam logic [7:0] CMD_COL_E   = 8'h07;
  localparam logic [7:0] CMD_GRAM_WR = 8'h0F;

  typedef enum logic [1:0] {StIdle, StCmd, StGram} bus_state_e;

  function automatic logic [15:0] clamp_to(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mcu_bus_decoder_fifo.sv
// First-word-fall-through synchronous FIFO for {data,x,y} pixel entries.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module pix_fifo #(
  parameter int unsigned Width = 35,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             wr_en, rd_en;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign wr_en   = push_i & (~full_o | pop_i);
  assign rd_en   = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/mcu_bus_decoder.sv
// 8080-style MCU bus decoder: control registers plus window-walking pixel stream.
// Optional register readback on DATA is enabled by defining MCU_READBACK_EN.
module mcu_bus_decoder
  import tft_bus_defs_pkg::*;
#(
  parameter int unsigned H_RES       = HResDefault,
  parameter int unsigned V_RES       = VResDefault,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        CS,
  input  logic        RS,
  input  logic        WR,
  input  logic        RD,
  inout  wire  [15:0] DATA,
  output logic [3:0]  pwm_level,
  output logic [8:0]  row_s,
  output logic [8:0]  row_e,
  output logic [9:0]  col_s,
  output logic [9:0]  col_e,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        ovf
);

  localparam int unsigned PixW = 16 + 10 + 9;

  logic [SYNC_STAGES-1:0] cs_sync_q, rs_sync_q, wr_sync_q;
  logic [15:0]            data_sync_q [SYNC_STAGES];
  logic                   wr_prev_q;
  logic                   cs_s, rs_s, wr_s, wr_evt;
  logic [15:0]            data_s;

  bus_state_e  state_q;
  logic [7:0]  cmd_q;
  logic [3:0]  pwm_q;
  logic [8:0]  row_s_q, row_e_q, win_rs_q, win_re_q, y_q;
  logic [9:0]  col_s_q, col_e_q, win_cs_q, win_ce_q, x_q;
  logic        ovf_q;

  logic            pix_push, pix_pop, fifo_full, fifo_empty, ovf_set;
  logic [PixW-1:0] fifo_head;

  always_ff @(posedge clk) begin
    if (RST) begin
      cs_sync_q <= '1;
      rs_sync_q <= '0;
      wr_sync_q <= '1;
      wr_prev_q <= 1'b1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
    end else begin
      cs_sync_q      <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      rs_sync_q      <= {rs_sync_q[SYNC_STAGES-2:0], RS};
      wr_sync_q      <= {wr_sync_q[SYNC_STAGES-2:0], WR};
      wr_prev_q      <= wr_s;
      data_sync_q[0] <= DATA;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rs_s   = rs_sync_q[SYNC_STAGES-1];
  assign wr_s   = wr_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign wr_evt = wr_s & ~wr_prev_q & ~cs_s;

  assign pix_push = wr_evt & rs_s & (state_q == StGram);
  assign pix_pop  = ~fifo_empty & pix_ready;
  assign ovf_set  = pix_push & fifo_full & ~pix_pop;

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= StIdle;
      cmd_q    <= '0;
      pwm_q    <= '0;
      row_s_q  <= '0;
      col_s_q  <= '0;
      row_e_q  <= 9'(V_RES - 1);
      col_e_q  <= 10'(H_RES - 1);
      win_rs_q <= '0;
      win_re_q <= '0;
      win_cs_q <= '0;
      win_ce_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (cs_s) begin
        state_q <= StIdle;
      end else if (wr_evt && !rs_s) begin
        cmd_q <= data_s[7:0];
        if (data_s[7:0] == CMD_GRAM_WR) begin
          // Latch the walk window so later window edits wait for the next 0x0F.
          state_q  <= StGram;
          x_q      <= col_s_q;
          y_q      <= row_s_q;
          ovf_q    <= 1'b0;
          win_cs_q <= col_s_q;
          win_ce_q <= (col_e_q < col_s_q) ? col_s_q : col_e_q;
          win_rs_q <= row_s_q;
          win_re_q <= (row_e_q < row_s_q) ? row_s_q : row_e_q;
        end else begin
          state_q <= StCmd;
        end
      end else if (wr_evt && state_q == StCmd) begin
        case (cmd_q)
          CMD_PWM:   pwm_q   <= data_s[3:0];
          CMD_ROW_S: row_s_q <= 9'(clamp_to(data_s, 16'(V_RES - 1)));
          CMD_COL_S: col_s_q <= 10'(clamp_to(data_s, 16'(H_RES - 1)));
          CMD_ROW_E: row_e_q <= 9'(clamp_to(data_s, 16'(V_RES - 1)));
          CMD_COL_E: col_e_q <= 10'(clamp_to(data_s, 16'(H_RES - 1)));
          default:   ;
        endcase
      end else if (pix_push) begin
        if (x_q == win_ce_q) begin
          x_q <= win_cs_q;
          y_q <= (y_q == win_re_q) ? win_rs_q : y_q + 9'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  pix_fifo #(
    .Width (PixW),
    .Depth (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk_i   (clk),
    .rst_i   (RST),
    .push_i  (pix_push),
    .wdata_i ({data_s, x_q, y_q}),
    .pop_i   (pix_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = fifo_head[34:19];
  assign pix_x     = fifo_head[18:9];
  assign pix_y     = fifo_head[8:0];
  assign pwm_level = pwm_q;
  assign row_s     = row_s_q;
  assign row_e     = row_e_q;
  assign col_s     = col_s_q;
  assign col_e     = col_e_q;
  assign ovf       = ovf_q;

`ifdef MCU_READBACK_EN
  logic [SYNC_STAGES-1:0] rd_sync_q;
  logic                   rd_s;
  logic [15:0]            rb_data;

  always_ff @(posedge clk) begin
    if (RST) rd_sync_q <= '1;
    else     rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], RD};
  end
  assign rd_s = rd_sync_q[SYNC_STAGES-1];

  always_comb begin
    rb_data = '0;
    case (cmd_q)
      CMD_PWM:   rb_data = {12'h000, pwm_q};
      CMD_ROW_S: rb_data = {7'h00, row_s_q};
      CMD_COL_S: rb_data = {6'h00, col_s_q};
      CMD_ROW_E: rb_data = {7'h00, row_e_q};
      CMD_COL_E: rb_data = {6'h00, col_e_q};
      default:   rb_data = '0;
    endcase
  end

  assign DATA = (!cs_s && rs_s && !rd_s) ? rb_data : 16'hzzzz;
`else
  logic unused_rd;
  assign unused_rd = RD;
  assign DATA      = 16'hzzzz;
`endif

endmodule

// File: tb/tb_mcu_bus_decoder.sv
// Self-checking bench for mcu_bus_decoder: window/pixel model plus directed vectors.
module tb_mcu_bus_decoder;

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic        CS = 1'b1, RS = 1'b0, WR = 1'b1, RD = 1'b1, pix_ready = 1'b0;
  logic [15:0] tb_data = 16'h0000;
  logic        tb_oe = 1'b1;
  wire  [15:0] DATA;
  logic [3:0]  pwm_level;
  logic [8:0]  row_s, row_e, pix_y;
  logic [9:0]  col_s, col_e, pix_x;
  logic        pix_valid, ovf;
  logic [15:0] pix_data;

  assign DATA = tb_oe ? tb_data : 16'hzzzz;

  mcu_bus_decoder dut (
    .clk       (clk),
    .RST       (RST),
    .CS        (CS),
    .RS        (RS),
    .WR        (WR),
    .RD        (RD),
    .DATA      (DATA),
    .pwm_level (pwm_level),
    .row_s     (row_s),
    .row_e     (row_e),
    .col_s     (col_s),
    .col_e     (col_e),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit settled = 1'b0;

  // Model: 0 idle, 1 command, 2 GRAM
  int m_state = 0, m_cmd = 0, m_pwm = 0, m_ovf = 0;
  int m_row_s = 0, m_row_e = 479, m_col_s = 0, m_col_e = 799;
  int mw_cs = 0, mw_w = 1, mw_rs = 0, mw_h = 1, m_n = 0;
  int eq_x[$], eq_y[$], eq_d[$];
  int cap_x[128], cap_y[128], cap_d[128];
  int gidx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    m_state = 0; m_cmd = 0; m_pwm = 0; m_ovf = 0;
    m_row_s = 0; m_row_e = 479; m_col_s = 0; m_col_e = 799;
    eq_x.delete(); eq_y.delete(); eq_d.delete();
  endtask

  task automatic mdl_write(input bit rs, input int d);
    if (!rs) begin
      m_cmd = d & 255;
      if (m_cmd == 15) begin
        m_state = 2; m_n = 0; m_ovf = 0; gidx = 0;
        mw_cs = m_col_s; mw_rs = m_row_s;
        mw_w  = (m_col_e >= m_col_s) ? m_col_e - m_col_s + 1 : 1;
        mw_h  = (m_row_e >= m_row_s) ? m_row_e - m_row_s + 1 : 1;
      end else begin
        m_state = 1;
      end
    end else if (m_state == 1) begin
      case (m_cmd)
        1: m_pwm   = d & 15;
        2: m_row_s = (d > 479) ? 479 : d;
        3: m_col_s = (d > 799) ? 799 : d;
        6: m_row_e = (d > 479) ? 479 : d;
        7: m_col_e = (d > 799) ? 799 : d;
        default: ;
      endcase
    end else if (m_state == 2) begin
      if (eq_x.size() < 2) begin
        eq_x.push_back(mw_cs + m_n % mw_w);
        eq_y.push_back(mw_rs + (m_n / mw_w) % mw_h);
        eq_d.push_back(d);
      end else begin
        m_ovf = 1;
      end
      m_n++;
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mcu_write(input bit rs, input logic [15:0] d);
    settled = 1'b0;
    clks(1);
    RS = rs; tb_data = d;
    clks(2);
    WR = 1'b0;
    clks(3);
    WR = 1'b1;
    mdl_write(rs, int'(d));
    clks(6);
    settled = 1'b1;
  endtask

  task automatic cmd_data(input logic [7:0] c, input logic [15:0] d);
    mcu_write(1'b0, {8'h00, c});
    mcu_write(1'b1, d);
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      if (settled) begin
        chk("pwm_level", int'(pwm_level), m_pwm);
        chk("row_s", int'(row_s), m_row_s);
        chk("row_e", int'(row_e), m_row_e);
        chk("col_s", int'(col_s), m_col_s);
        chk("col_e", int'(col_e), m_col_e);
        chk("ovf", int'(ovf), m_ovf);
        chk("pix_valid", int'(pix_valid), int'(eq_x.size() != 0));
      end
      if (pix_valid && pix_ready) begin
        if (eq_x.size() == 0) begin
          chk("unexpected_pixel_count", 1, 0);
        end else begin
          chk("pix_x", int'(pix_x), eq_x[0]);
          chk("pix_y", int'(pix_y), eq_y[0]);
          chk("pix_data", int'(pix_data), eq_d[0]);
          void'(eq_x.pop_front()); void'(eq_y.pop_front()); void'(eq_d.pop_front());
          if (gidx < 128) begin
            cap_x[gidx] = int'(pix_x); cap_y[gidx] = int'(pix_y); cap_d[gidx] = int'(pix_data);
          end
          gidx++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset
    clks(3);
    RST = 1'b0;
    mdl_reset();
    clks(1);
    chk("rst_pwm", int'(pwm_level), 0);
    chk("rst_row_e", int'(row_e), 479);
    chk("rst_col_e", int'(col_e), 799);
    chk("rst_row_s", int'(row_s), 0);
    chk("rst_col_s", int'(col_s), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    settled = 1'b1;

    // 2: PWM write, then RS=1 in IDLE after a CS cycle is ignored
    CS = 1'b0;
    clks(4);
    cmd_data(8'h01, 16'h0002);
    chk("pwm_after_write", int'(pwm_level), 2);
    CS = 1'b1; m_state = 0;
    clks(4);
    CS = 1'b0;
    clks(4);
    mcu_write(1'b1, 16'h0009);
    chk("pwm_idle_ignored", int'(pwm_level), 2);

    // 3: window walk with wrap
    pix_ready = 1'b1;
    cmd_data(8'h02, 16'd470);
    cmd_data(8'h06, 16'd479);
    cmd_data(8'h03, 16'd790);
    cmd_data(8'h07, 16'd799);
    mcu_write(1'b0, 16'h000F);
    for (int i = 0; i <= 100; i++) mcu_write(1'b1, 16'(16'h001F + i));
    chk("px0_x", cap_x[0], 790);
    chk("px0_y", cap_y[0], 470);
    chk("px0_d", cap_d[0], 16'h001F);
    chk("px9_x", cap_x[9], 799);
    chk("px9_d", cap_d[9], 16'h0028);
    chk("px10_x", cap_x[10], 790);
    chk("px10_y", cap_y[10], 471);
    chk("px100_x", cap_x[100], 790);
    chk("px100_y", cap_y[100], 470);
    chk("px100_d", cap_d[100], 16'h0083);

    // 4: overflow with ready low, cleared by 0x0F
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) mcu_write(1'b1, 16'(16'h0200 + i));
    chk("ovf_set", int'(ovf), 1);
    chk("fifo_held_valid", int'(pix_valid), 1);
    mcu_write(1'b0, 16'h000F);
    chk("ovf_cleared", int'(ovf), 0);
    pix_ready = 1'b1;
    clks(10);
    chk("fifo_drained", eq_x.size(), 0);

    // end < start collapses to a single column
    cmd_data(8'h03, 16'd5);
    cmd_data(8'h07, 16'd3);
    cmd_data(8'h02, 16'd0);
    cmd_data(8'h06, 16'd1);
    mcu_write(1'b0, 16'h000F);
    for (int i = 0; i < 3; i++) mcu_write(1'b1, 16'(16'h0100 + i));
    chk("col1_x", cap_x[1], 5);
    chk("col1_y", cap_y[1], 1);
    chk("col2_y", cap_y[2], 0);

    // 5: clamping, then reset mid-burst
    cmd_data(8'h07, 16'd900);
    chk("col_e_clamp", int'(col_e), 799);
    cmd_data(8'h06, 16'd500);
    chk("row_e_clamp", int'(row_e), 479);
    mcu_write(1'b0, 16'h000F);
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) mcu_write(1'b1, 16'(16'h0300 + i));
    chk("pre_rst_valid", int'(pix_valid), 1);
    settled = 1'b0;
    RST = 1'b1;
    clks(1);
    chk("rst_flush_valid", int'(pix_valid), 0);
    chk("rst_col_e_mid", int'(col_e), 799);
    chk("rst_col_s_mid", int'(col_s), 0);
    clks(2);
    RST = 1'b0;
    mdl_reset();
    clks(4);
    settled = 1'b1;
    mcu_write(1'b1, 16'h0055);
    chk("post_rst_idle_valid", int'(pix_valid), 0);
    chk("post_rst_idle_pwm", int'(pwm_level), 0);

    // 6: DATA readback / no-drive
    mcu_write(1'b0, 16'h0007);
    RS = 1'b1; RD = 1'b0;
`ifdef MCU_READBACK_EN
    tb_oe = 1'b0;
    clks(6);
    chk("readback_col_e", int'(DATA), 799);
    RD = 1'b1;
    clks(6);
    tb_oe = 1'b1;
`else
    tb_data = 16'hA5C3;
    clks(6);
    chk("data_not_driven", int'(DATA), 16'hA5C3);
    RD = 1'b1;
`endif
    clks(4);
    CS = 1'b1;
    clks(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
